vending_machine_param: RTL

//  Parametrised vending controller: accumulates nickel/dime/quarter credit, vends at PRICE,

---
 rtl/vending_pkg.sv | 17 +
 rtl/vending_change_select.sv | 29 ++
 rtl/vending_machine_param.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared types and coin values for the vending controller.
// All values are in nickel units.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2,
    REFUND = 2'd3
  } state_t;

  localparam int NICKEL_V  = 1;
  localparam int DIME_V    = 2;
  localparam int QUARTER_V = 5;
  localparam int DDIME_V   = 4;

endpackage

// File: rtl/vending_change_select.sv
// Greedy change selector: picks the largest payable coin for the current credit
// and reports how much credit that coin removes.
module vending_change_select
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 4
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [2:0]          give_onehot,  // {doubledime, dime, nickel}
  output logic [CREDIT_W-1:0] decrement
);

  // Largest-coin-first selection
  always_comb begin
    give_onehot = 3'b000;
    decrement   = '0;
    if (credit >= CREDIT_W'(DDIME_V)) begin
      give_onehot = 3'b100;
      decrement   = CREDIT_W'(DDIME_V);
    end else if (credit >= CREDIT_W'(DIME_V)) begin
      give_onehot = 3'b010;
      decrement   = CREDIT_W'(DIME_V);
    end else begin
      give_onehot = 3'b001;
      decrement   = CREDIT_W'(NICKEL_V);
    end
  end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: accumulates coin credit, vends at PRICE and
// pays out change or refunds one coin per cycle. Outputs decode from registers only.
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic                ready,
  output logic                deliver,
  output logic                give_nickel,
  output logic                give_dime,
  output logic                give_doubledime,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit
);

  // Max credit is PRICE-1 plus a quarter, which must fit the register
  if ((2**CREDIT_W <= PRICE + 4) || (PRICE < 1)) begin : g_param_check
    $error("vending_machine_param: PRICE out of range for CREDIT_W");
  end

  state_t                state_r, state_nxt_s;
  logic [CREDIT_W-1:0]   credit_r, credit_nxt_s;
  logic                  coin_reject_r, coin_reject_nxt_s;
  logic [CREDIT_W:0]     coin_value_s;
  logic [CREDIT_W:0]     sum_s;
  logic                  coin_legal_s;
  logic                  coin_any_s;
  logic [2:0]            give_onehot_s;
  logic [CREDIT_W-1:0]   change_dec_s;

  vending_change_select #(.CREDIT_W(CREDIT_W)) u_change_select (
    .credit      (credit_r),
    .give_onehot (give_onehot_s),
    .decrement   (change_dec_s)
  );

  // Coin decode: a legal coin is exactly one coin input high
  always_comb begin
    coin_value_s = '0;
    coin_legal_s = 1'b0;
    case ({quarter, dime, nickel})
      3'b001: begin coin_value_s = (CREDIT_W+1)'(NICKEL_V);  coin_legal_s = 1'b1; end
      3'b010: begin coin_value_s = (CREDIT_W+1)'(DIME_V);    coin_legal_s = 1'b1; end
      3'b100: begin coin_value_s = (CREDIT_W+1)'(QUARTER_V); coin_legal_s = 1'b1; end
      default: begin coin_value_s = '0; coin_legal_s = 1'b0; end
    endcase
    coin_any_s = nickel | dime | quarter;
    sum_s      = {1'b0, credit_r} + coin_value_s;
  end

  // Next-state, next-credit and coin-reject decision
  always_comb begin
    state_nxt_s       = state_r;
    credit_nxt_s      = credit_r;
    coin_reject_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cancel) begin
          // A coin arriving with cancel is never credited
          coin_reject_nxt_s = coin_any_s;
          if (credit_r != '0) begin
            state_nxt_s = REFUND;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (coin_legal_s) begin
          credit_nxt_s = sum_s[CREDIT_W-1:0];
          if (sum_s >= (CREDIT_W+1)'(PRICE)) begin
            state_nxt_s = VEND;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          coin_reject_nxt_s = coin_any_s;
        end
      end
      VEND: begin
        coin_reject_nxt_s = coin_any_s;
        credit_nxt_s      = credit_r - CREDIT_W'(PRICE);
        if (credit_r != CREDIT_W'(PRICE)) begin
          state_nxt_s = CHANGE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CHANGE, REFUND: begin
        coin_reject_nxt_s = coin_any_s;
        credit_nxt_s      = credit_r - change_dec_s;
        if (credit_r <= change_dec_s) begin
          credit_nxt_s = '0;
          state_nxt_s  = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        credit_nxt_s = '0;
      end
    endcase
  end

  // State, credit and reject registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= IDLE;
      credit_r      <= '0;
      coin_reject_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      credit_r      <= credit_nxt_s;
      coin_reject_r <= coin_reject_nxt_s;
    end
  end

  // Output decode from registered state only
  always_comb begin
    ready           = (state_r == IDLE);
    deliver         = (state_r == VEND);
    coin_reject     = coin_reject_r;
    credit          = credit_r;
    give_doubledime = 1'b0;
    give_dime       = 1'b0;
    give_nickel     = 1'b0;
    if ((state_r == CHANGE) || (state_r == REFUND)) begin
      {give_doubledime, give_dime, give_nickel} = give_onehot_s;
    end else begin
      {give_doubledime, give_dime, give_nickel} = 3'b000;
    end
  end

endmodule
